// File: rtl/decode_stage_hs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage_hs_pkg
// Description : Shared constants and helpers for the RV32I_Zicsr decode stage:
//               opcodes, one-hot ALU op bit indices, CSR op codes.
// Revision    : 2.0 - second-generation decode with handshake and Zicsr
// ============================================================================
package decode_stage_hs_pkg;

  // Architectural register address width (fixed even for RV32E).
  localparam int unsigned XADDR     = 5;
  // Width of the one-hot ALU op vector.
  localparam int unsigned c_aluops  = 14;

  // Major opcodes
  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_misc   = 7'b0001111;
  localparam logic [6:0] c_op_opimm  = 7'b0010011;
  localparam logic [6:0] c_op_auipc  = 7'b0010111;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_op     = 7'b0110011;
  localparam logic [6:0] c_op_lui    = 7'b0110111;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_jalr   = 7'b1100111;
  localparam logic [6:0] c_op_jal    = 7'b1101111;
  localparam logic [6:0] c_op_system = 7'b1110011;

  // ALU op bit indices within the one-hot vector
  localparam int unsigned c_alu_add  = 0;
  localparam int unsigned c_alu_sub  = 1;
  localparam int unsigned c_alu_sll  = 2;
  localparam int unsigned c_alu_slt  = 3;
  localparam int unsigned c_alu_sltu = 4;
  localparam int unsigned c_alu_xor  = 5;
  localparam int unsigned c_alu_srl  = 6;
  localparam int unsigned c_alu_sra  = 7;
  localparam int unsigned c_alu_or   = 8;
  localparam int unsigned c_alu_and  = 9;
  localparam int unsigned c_alu_eq   = 10;
  localparam int unsigned c_alu_neq  = 11;
  localparam int unsigned c_alu_ge   = 12;
  localparam int unsigned c_alu_geu  = 13;

  // CSR op codes (match funct3[1:0] of the CSR instructions)
  localparam logic [1:0] c_csr_none = 2'b00;
  localparam logic [1:0] c_csr_rw   = 2'b01;
  localparam logic [1:0] c_csr_rs   = 2'b10;
  localparam logic [1:0] c_csr_rc   = 2'b11;

  // One-hot vector with only bit idx set.
  function automatic logic [c_aluops-1:0] alu_onehot(input int unsigned idx);
    alu_onehot      = '0;
    alu_onehot[idx] = 1'b1;
  endfunction

  // Register/immediate arithmetic op; alt selects SUB/SRA.
  function automatic logic [c_aluops-1:0] arith_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  arith_op = alu_onehot(alt ? c_alu_sub : c_alu_add);
      3'b001:  arith_op = alu_onehot(c_alu_sll);
      3'b010:  arith_op = alu_onehot(c_alu_slt);
      3'b011:  arith_op = alu_onehot(c_alu_sltu);
      3'b100:  arith_op = alu_onehot(c_alu_xor);
      3'b101:  arith_op = alu_onehot(alt ? c_alu_sra : c_alu_srl);
      3'b110:  arith_op = alu_onehot(c_alu_or);
      default: arith_op = alu_onehot(c_alu_and);
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/decode_stage_hs_imm_gen.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage_hs_imm_gen
// Description : Combinational immediate select by opcode, sign-extended to
//               XLEN; CSR forms produce the zero-extended uimm field.
// Revision    : 2.0 - adds CSR uimm
// ============================================================================
module decode_stage_hs_imm_gen
  import decode_stage_hs_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     i_inst,
  output logic [XLEN-1:0] o_imm
);

  logic signed [31:0] w_imm32;

  // Pick the immediate format from the opcode.
  always_comb begin
    w_imm32 = '0;
    case (i_inst[6:0])
      c_op_opimm, c_op_load, c_op_jalr:
        w_imm32 = {{20{i_inst[31]}}, i_inst[31:20]};
      c_op_store:
        w_imm32 = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
      c_op_branch:
        w_imm32 = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
      c_op_lui, c_op_auipc:
        w_imm32 = {i_inst[31:12], 12'b0};
      c_op_jal:
        w_imm32 = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
      c_op_system:
        if (i_inst[14:12] != 3'b000) w_imm32 = {27'b0, i_inst[19:15]};
      default:
        w_imm32 = '0;
    endcase
  end

  // Signed size cast sign-extends to XLEN.
  assign o_imm = XLEN'(w_imm32);

endmodule
`default_nettype wire

// File: rtl/decode_stage_hs_register_file.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage_hs_register_file
// Description : NREGS x XLEN register file, two read ports with same-cycle
//               writeback bypass; x0 and addresses >= NREGS read as zero.
// Revision    : 2.0 - parametrised for RV32E
// ============================================================================
module decode_stage_hs_register_file
  import decode_stage_hs_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_wb_en,
  input  logic [XADDR-1:0] i_wb_addr,
  input  logic [XLEN-1:0]  i_wb_data,
  input  logic [XADDR-1:0] i_rs1_addr,
  input  logic [XADDR-1:0] i_rs2_addr,
  output logic [XLEN-1:0]  o_rs1_data,
  output logic [XLEN-1:0]  o_rs2_data
);

  logic [XLEN-1:0] w_file [2**XADDR];

  // Only entries 1..NREGS-1 hold state; the rest are tied to zero.
  for (genvar gi = 0; gi < 2**XADDR; gi++) begin : g_entry
    if (gi == 0 || gi >= NREGS) begin : g_zero
      assign w_file[gi] = '0;
    end else begin : g_reg
      logic [XLEN-1:0] r_q;
      // Entry register: cleared on reset, loaded on matching writeback.
      always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
          r_q <= '0;
        end else if (i_wb_en && i_wb_addr == XADDR'(gi)) begin
          r_q <= i_wb_data;
        end
      end
      assign w_file[gi] = r_q;
    end
  end

  // Read ports: forward writeback data that lands this cycle.
  always_comb begin
    o_rs1_data = w_file[i_rs1_addr];
    o_rs2_data = w_file[i_rs2_addr];
    if (i_wb_en && i_wb_addr == i_rs1_addr && i_rs1_addr != '0) o_rs1_data = i_wb_data;
    if (i_wb_en && i_wb_addr == i_rs2_addr && i_rs2_addr != '0) o_rs2_data = i_wb_data;
  end

endmodule
`default_nettype wire

// File: rtl/decode_stage_hs.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage_hs
// Description : RV32I_Zicsr decode stage with valid/ready handshake, flush,
//               load-use hazard stall, register file with WB bypass and an
//               illegal-instruction flag. Registered ID/EX bundle.
// Revision    : 2.0 - second generation
// ============================================================================
module decode_stage_hs
  import decode_stage_hs_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned ALUOPS = c_aluops
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [31:0]       i_inst,
  input  logic [XLEN-1:0]   i_pc,
  input  logic              i_flush,
  input  logic              i_wb_en,
  input  logic [XADDR-1:0]  i_wb_addr,
  input  logic [XLEN-1:0]   i_wb_data,
  input  logic              i_ex_is_load,
  input  logic [XADDR-1:0]  i_ex_rd_addr,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [6:0]        or_opcode,
  output logic [2:0]        or_funct3,
  output logic [6:0]        or_funct7,
  output logic [XADDR-1:0]  or_rd_addr,
  output logic [XADDR-1:0]  or_rs1_addr,
  output logic [XADDR-1:0]  or_rs2_addr,
  output logic [XLEN-1:0]   or_rs1_data,
  output logic [XLEN-1:0]   or_rs2_data,
  output logic [XLEN-1:0]   or_imm,
  output logic [XLEN-1:0]   or_pc,
  output logic [ALUOPS-1:0] or_alu_op,
  output logic [11:0]       or_csr_addr,
  output logic [1:0]        or_csr_op,
  output logic              or_csr_imm,
  output logic              or_illegal
);

  localparam logic [XADDR:0] c_nregs = (XADDR+1)'(NREGS);

  logic [6:0]          w_opcode;
  logic [2:0]          w_funct3;
  logic [6:0]          w_funct7;
  logic [XADDR-1:0]    w_rd, w_rs1, w_rs2;
  logic                w_f7_zero, w_f7_alt;
  logic                w_rd_used, w_rs1_used, w_rs2_used;
  logic [c_aluops-1:0] w_alu;
  logic                w_illegal;
  logic [11:0]         w_csr_addr;
  logic [1:0]          w_csr_op;
  logic                w_csr_imm;
  logic [XLEN-1:0]     w_imm, w_rs1_data, w_rs2_data;
  logic                w_hazard, w_capture;

  assign w_opcode  = i_inst[6:0];
  assign w_funct3  = i_inst[14:12];
  assign w_funct7  = i_inst[31:25];
  assign w_rd      = i_inst[11:7];
  assign w_rs1     = i_inst[19:15];
  assign w_rs2     = i_inst[24:20];
  assign w_f7_zero = (w_funct7 == 7'b0000000);
  assign w_f7_alt  = (w_funct7 == 7'b0100000);

  decode_stage_hs_register_file #(.XLEN(XLEN), .NREGS(NREGS)) u_regfile (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_wb_en    (i_wb_en),
    .i_wb_addr  (i_wb_addr),
    .i_wb_data  (i_wb_data),
    .i_rs1_addr (w_rs1),
    .i_rs2_addr (w_rs2),
    .o_rs1_data (w_rs1_data),
    .o_rs2_data (w_rs2_data)
  );

  decode_stage_hs_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .i_inst (i_inst),
    .o_imm  (w_imm)
  );

  // Instruction decode: operand usage, ALU op, CSR fields, legality.
  always_comb begin
    w_rd_used  = 1'b0;
    w_rs1_used = 1'b0;
    w_rs2_used = 1'b0;
    w_alu      = '0;
    w_illegal  = 1'b0;
    w_csr_addr = '0;
    w_csr_op   = c_csr_none;
    w_csr_imm  = 1'b0;
    case (w_opcode)
      c_op_op: begin
        w_rd_used  = 1'b1;
        w_rs1_used = 1'b1;
        w_rs2_used = 1'b1;
        w_alu      = arith_op(w_funct3, w_f7_alt);
        if (!(w_f7_zero || (w_f7_alt && (w_funct3 == 3'b000 || w_funct3 == 3'b101))))
          w_illegal = 1'b1;
      end
      c_op_opimm: begin
        w_rd_used  = 1'b1;
        w_rs1_used = 1'b1;
        w_alu      = arith_op(w_funct3, w_f7_alt && w_funct3 == 3'b101);
        if ((w_funct3 == 3'b001 && !w_f7_zero) ||
            (w_funct3 == 3'b101 && !(w_f7_zero || w_f7_alt)))
          w_illegal = 1'b1;
      end
      c_op_branch: begin
        w_rs1_used = 1'b1;
        w_rs2_used = 1'b1;
        case (w_funct3)
          3'b000:  w_alu = alu_onehot(c_alu_eq);
          3'b001:  w_alu = alu_onehot(c_alu_neq);
          3'b100:  w_alu = alu_onehot(c_alu_slt);
          3'b101:  w_alu = alu_onehot(c_alu_ge);
          3'b110:  w_alu = alu_onehot(c_alu_sltu);
          3'b111:  w_alu = alu_onehot(c_alu_geu);
          default: w_illegal = 1'b1;
        endcase
      end
      c_op_load: begin
        w_rd_used  = 1'b1;
        w_rs1_used = 1'b1;
        if (w_funct3 == 3'b011 || w_funct3[2:1] == 2'b11) w_illegal = 1'b1;
      end
      c_op_store: begin
        w_rs1_used = 1'b1;
        w_rs2_used = 1'b1;
        if (w_funct3[2] || w_funct3 == 3'b011) w_illegal = 1'b1;
      end
      c_op_jalr: begin
        w_rd_used  = 1'b1;
        w_rs1_used = 1'b1;
        if (w_funct3 != 3'b000) w_illegal = 1'b1;
      end
      c_op_jal, c_op_lui, c_op_auipc: begin
        w_rd_used = 1'b1;
      end
      c_op_misc: begin
        w_illegal = 1'b0;
      end
      c_op_system: begin
        if (w_funct3 == 3'b000) begin
          // Only ECALL and EBREAK are supported privileged encodings.
          if (i_inst != 32'h0000_0073 && i_inst != 32'h0010_0073) w_illegal = 1'b1;
        end else if (w_funct3 == 3'b100) begin
          w_illegal = 1'b1;
        end else begin
          w_rd_used  = 1'b1;
          w_rs1_used = !w_funct3[2];
          w_csr_addr = i_inst[31:20];
          w_csr_op   = w_funct3[1:0];
          w_csr_imm  = w_funct3[2];
        end
      end
      default: w_illegal = 1'b1;
    endcase
    if (i_inst[1:0] != 2'b11) w_illegal = 1'b1;
    // Register addresses beyond the implemented file (RV32E).
    if ((w_rd_used  && {1'b0, w_rd}  >= c_nregs) ||
        (w_rs1_used && {1'b0, w_rs1} >= c_nregs) ||
        (w_rs2_used && {1'b0, w_rs2} >= c_nregs))
      w_illegal = 1'b1;
  end

  // Load-use hazard and handshake.
  always_comb begin
    w_hazard = i_valid && i_ex_is_load && (i_ex_rd_addr != '0) &&
               ((w_rs1_used && w_rs1 == i_ex_rd_addr) ||
                (w_rs2_used && w_rs2 == i_ex_rd_addr));
    o_ready   = (!o_valid || i_ready) && !w_hazard && !i_flush;
    w_capture = i_valid && o_ready;
  end

  // Bundle valid: flush kills, capture sets, downstream take clears.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)       o_valid <= 1'b0;
    else if (i_flush)   o_valid <= 1'b0;
    else if (w_capture) o_valid <= 1'b1;
    else if (i_ready)   o_valid <= 1'b0;
  end

  // Bundle payload: loaded on capture, otherwise held stable.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      or_opcode   <= '0;
      or_funct3   <= '0;
      or_funct7   <= '0;
      or_rd_addr  <= '0;
      or_rs1_addr <= '0;
      or_rs2_addr <= '0;
      or_rs1_data <= '0;
      or_rs2_data <= '0;
      or_imm      <= '0;
      or_pc       <= '0;
      or_alu_op   <= '0;
      or_csr_addr <= '0;
      or_csr_op   <= '0;
      or_csr_imm  <= 1'b0;
      or_illegal  <= 1'b0;
    end else if (w_capture) begin
      or_opcode   <= w_opcode;
      or_funct3   <= w_funct3;
      or_funct7   <= w_funct7;
      or_rd_addr  <= w_rd;
      or_rs1_addr <= w_rs1;
      or_rs2_addr <= w_rs2;
      or_rs1_data <= w_rs1_data;
      or_rs2_data <= w_rs2_data;
      or_imm      <= w_imm;
      or_pc       <= i_pc;
      or_alu_op   <= ALUOPS'(w_alu);
      or_csr_addr <= w_csr_addr;
      or_csr_op   <= w_csr_op;
      or_csr_imm  <= w_csr_imm;
      or_illegal  <= w_illegal;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_decode_stage_hs.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_stage_hs
// Description : Directed self-checking bench for decode_stage_hs (RV32I
//               instance plus an RV32E instance sharing the same stimulus).
// Revision    : 2.0
// ============================================================================
module tb_decode_stage_hs;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid, flush, wb_en, ex_is_load, ready;
  logic [31:0] inst, pc, wb_data;
  logic [4:0]  wb_addr, ex_rd;

  logic        o_ready, o_valid;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] rs1_data, rs2_data, imm, opc;
  logic [13:0] alu;
  logic [11:0] csr_addr;
  logic [1:0]  csr_op;
  logic        csr_imm, illegal;

  logic        e_ready, e_valid;
  logic [6:0]  e_opcode, e_funct7;
  logic [2:0]  e_funct3;
  logic [4:0]  e_rd, e_rs1, e_rs2;
  logic [31:0] e_rs1_data, e_rs2_data, e_imm, e_pc;
  logic [13:0] e_alu;
  logic [11:0] e_csr_addr;
  logic [1:0]  e_csr_op;
  logic        e_csr_imm, e_illegal;

  int checks = 0;
  int errors = 0;

  // Expected one-hot ALU codes
  localparam logic [13:0] ADD = 14'h0001, SUB = 14'h0002, NEQ = 14'h0800;

  always #5 clk = ~clk;

  decode_stage_hs dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(o_ready),
    .i_inst(inst), .i_pc(pc), .i_flush(flush), .i_wb_en(wb_en),
    .i_wb_addr(wb_addr), .i_wb_data(wb_data), .i_ex_is_load(ex_is_load),
    .i_ex_rd_addr(ex_rd), .o_valid(o_valid), .i_ready(ready),
    .or_opcode(opcode), .or_funct3(funct3), .or_funct7(funct7),
    .or_rd_addr(rd), .or_rs1_addr(rs1), .or_rs2_addr(rs2),
    .or_rs1_data(rs1_data), .or_rs2_data(rs2_data), .or_imm(imm), .or_pc(opc),
    .or_alu_op(alu), .or_csr_addr(csr_addr), .or_csr_op(csr_op),
    .or_csr_imm(csr_imm), .or_illegal(illegal)
  );

  decode_stage_hs #(.NREGS(16)) dut_e (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(e_ready),
    .i_inst(inst), .i_pc(pc), .i_flush(flush), .i_wb_en(wb_en),
    .i_wb_addr(wb_addr), .i_wb_data(wb_data), .i_ex_is_load(ex_is_load),
    .i_ex_rd_addr(ex_rd), .o_valid(e_valid), .i_ready(ready),
    .or_opcode(e_opcode), .or_funct3(e_funct3), .or_funct7(e_funct7),
    .or_rd_addr(e_rd), .or_rs1_addr(e_rs1), .or_rs2_addr(e_rs2),
    .or_rs1_data(e_rs1_data), .or_rs2_data(e_rs2_data), .or_imm(e_imm), .or_pc(e_pc),
    .or_alu_op(e_alu), .or_csr_addr(e_csr_addr), .or_csr_op(e_csr_op),
    .or_csr_imm(e_csr_imm), .or_illegal(e_illegal)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; valid = 1'b0; flush = 1'b0; wb_en = 1'b0; ex_is_load = 1'b0;
    ready = 1'b1; inst = 32'h0000_0013; pc = '0; wb_data = '0; wb_addr = '0; ex_rd = '0;
    tick(); tick();
    chk("reset_valid", o_valid, 0);
    chk("reset_imm", imm, 0);
    chk("reset_alu", alu, 0);
    chk("reset_illegal", illegal, 0);

    // ADDI x1,x0,-5
    rst_n = 1'b1; valid = 1'b1; inst = 32'hFFB0_0093; pc = 32'h100;
    #1 chk("addi_ready", o_ready, 1);
    tick();
    chk("addi_valid", o_valid, 1);
    chk("addi_imm", imm, 32'hFFFF_FFFB);
    chk("addi_alu", alu, ADD);
    chk("addi_rd", rd, 1);
    chk("addi_pc", opc, 32'h100);
    chk("addi_illegal", illegal, 0);

    // SUB x3,x1,x2 with writeback x1=7 in the same cycle
    inst = 32'h4020_81B3; pc = 32'h104; wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'd7;
    tick();
    chk("sub_rs1_bypass", rs1_data, 7);
    chk("sub_rs2", rs2_data, 0);
    chk("sub_alu", alu, SUB);
    chk("sub_funct7", funct7, 7'h20);
    chk("sub_rd", rd, 3);

    // Idle cycle writing x2; bundle drains
    valid = 1'b0; wb_addr = 5'd2; wb_data = 32'h1234_5678;
    tick();
    chk("drain_valid", o_valid, 0);

    // Load-use hazard: ADD x6,x5,x0 while EX loads x5
    wb_en = 1'b0; valid = 1'b1; inst = 32'h0002_8333; ex_is_load = 1'b1; ex_rd = 5'd5;
    #1 chk("hazard_ready", o_ready, 0);
    tick();
    chk("hazard_bubble", o_valid, 0);
    ex_is_load = 1'b0;
    #1 chk("hazard_clear_ready", o_ready, 1);
    tick();
    chk("hazard_capture_valid", o_valid, 1);
    chk("hazard_capture_rd", rd, 6);
    chk("hazard_capture_rs1", rs1, 5);

    // ADD x7,x1,x2 reads stored file values
    inst = 32'h0020_83B3;
    tick();
    chk("file_rs1", rs1_data, 7);
    chk("file_rs2", rs2_data, 32'h1234_5678);

    // Backpressure for 3 cycles with a new instruction waiting
    ready = 1'b0; inst = 32'h0050_0113;
    #1 chk("stall_ready", o_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_valid", o_valid, 1);
      chk("stall_rd", rd, 7);
      chk("stall_rs2", rs2_data, 32'h1234_5678);
    end
    flush = 1'b1;
    #1 chk("flush_ready", o_ready, 0);
    tick();
    chk("flush_valid", o_valid, 0);
    flush = 1'b0; ready = 1'b1;
    tick();
    chk("post_flush_valid", o_valid, 1);
    chk("post_flush_imm", imm, 5);
    chk("post_flush_rd", rd, 2);

    // CSRRSI x4,mstatus,3 while EX loads x3 (uimm form must not stall)
    inst = 32'h3001_E273; ex_is_load = 1'b1; ex_rd = 5'd3;
    #1 chk("csr_no_hazard", o_ready, 1);
    tick();
    ex_is_load = 1'b0;
    chk("csr_addr", csr_addr, 12'h300);
    chk("csr_op", csr_op, 2'b10);
    chk("csr_imm_flag", csr_imm, 1);
    chk("csr_imm", imm, 3);
    chk("csr_alu", alu, 0);
    chk("csr_illegal", illegal, 0);

    // Unknown opcode 0x7F
    inst = 32'h0000_007F;
    tick();
    chk("bad_op_illegal", illegal, 1);
    chk("bad_op_valid", o_valid, 1);

    // ECALL is legal
    inst = 32'h0000_0073;
    tick();
    chk("ecall_illegal", illegal, 0);

    // BNE x1,x2,-4
    inst = 32'hFE20_9EE3;
    tick();
    chk("bne_imm", imm, 32'hFFFF_FFFC);
    chk("bne_alu", alu, NEQ);
    chk("bne_rs1", rs1_data, 7);

    // ADDI x20,x0,1: legal on RV32I, illegal on RV32E
    inst = 32'h0010_0A13;
    tick();
    chk("rv32i_x20_illegal", illegal, 0);
    chk("rv32e_x20_illegal", e_illegal, 1);
    chk("rv32e_x20_valid", e_valid, 1);

    valid = 1'b0;
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
